// File: rtl/dram_responder.sv
// DRAM-side responder: host-preloaded input memory with fixed-latency reads, result capture memory,
// and a small IDLE/RUN/DONE run tracker with a sticky protocol-error flag.
module dram_responder #(
  parameter int unsigned ADDR_W        = 10,
  parameter int unsigned DATA_W        = 64,
  parameter int unsigned READ_LAT      = 2,
  parameter int unsigned EXPECT_WRITES = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                host_we,
  input  logic [ADDR_W-1:0]   host_addr,
  input  logic [DATA_W-1:0]   host_wdata,
  input  logic                host_re,
  output logic [DATA_W-1:0]   host_rdata,
  input  logic                start,
  input  logic                DRAMreadEn,
  input  logic [ADDR_W-1:0]   DRAMreadAddr,
  input  logic                DRAMwriteEn,
  input  logic [ADDR_W-1:0]   DRAMwriteAddr,
  input  logic [DATA_W-1:0]   DRAMwriteData,
  output logic [DATA_W-1:0]   ifmap,
  output logic                readValid,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     wrCount,
  output logic                err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] EXP_CNT = CNT_W'(EXPECT_WRITES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  stateT              state, stateNext;
  logic [CNT_W-1:0]   wrCountNext;
  logic               errNext;
  logic               readAcc, writeAcc, imemWe, viol;

  logic [DATA_W-1:0]  imem [DEPTH];
  logic [DATA_W-1:0]  rmem [DEPTH];

  logic [READ_LAT-1:0] pipeValid;
  logic [DATA_W-1:0]   pipeData [READ_LAT];

  // Next-state, acceptance and violation decode
  always_comb begin
    stateNext   = state;
    wrCountNext = wrCount;
    errNext     = err;
    readAcc     = 1'b0;
    writeAcc    = 1'b0;
    imemWe      = 1'b0;
    viol        = 1'b0;
    case (state)
      IDLE, DONE: begin
        imemWe = host_we;
        viol   = DRAMreadEn | DRAMwriteEn;
        if (start) begin
          stateNext   = RUN;
          wrCountNext = '0;
          if (state == DONE) errNext = 1'b0;
        end
      end
      RUN: begin
        readAcc = DRAMreadEn;
        viol    = host_we;
        if (DRAMwriteEn) begin
          if (wrCount == EXP_CNT) begin
            viol = 1'b1;
          end else begin
            writeAcc    = 1'b1;
            wrCountNext = wrCount + CNT_W'(1);
          end
        end
        if ((wrCount == EXP_CNT) && (pipeValid == '0)) stateNext = DONE;
      end
      default: stateNext = IDLE;
    endcase
    if (viol) errNext = 1'b1;
  end

  // State and registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      wrCount <= '0;
      err     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= stateNext;
      wrCount <= wrCountNext;
      err     <= errNext;
      busy    <= (stateNext == RUN);
      done    <= (stateNext == DONE);
    end
  end

  // Unreset storage arrays; contents survive reset
  always_ff @(posedge clk) begin
    if (imemWe)   imem[host_addr]     <= host_wdata;
    if (writeAcc) rmem[DRAMwriteAddr] <= DRAMwriteData;
  end

  // Host result read; old word is returned on a same-address accelerator write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) host_rdata <= '0;
    else if (host_re) host_rdata <= rmem[host_addr];
  end

  // Read pipeline; data stages only advance with valid so the output holds the last response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipeValid <= '0;
      for (int i = 0; i < READ_LAT; i++) pipeData[i] <= '0;
    end else begin
      pipeValid[0] <= readAcc;
      if (readAcc) pipeData[0] <= imem[DRAMreadAddr];
      for (int i = 1; i < READ_LAT; i++) begin
        pipeValid[i] <= pipeValid[i-1];
        if (pipeValid[i-1]) pipeData[i] <= pipeData[i-1];
      end
    end
  end

  assign readValid = pipeValid[READ_LAT-1];
  assign ifmap     = pipeData[READ_LAT-1];

endmodule

// File: doc/dram_responder.md
# dram_responder

Memory-side responder for the accelerator's DRAM interface. Holds the input image (ifmap, packed weights and bias words, preloaded by the host) and answers the accelerator's `DRAMreadEn`/`DRAMreadAddr` requests with 64-bit words after a fixed latency. It captures the accelerator's `DRAMwriteEn`/`DRAMwriteAddr`/`DRAMwriteData` max-pool results into a separate result memory. It tracks run completion for the host.

## Interface
- `ADDR_W`, 10, address width of both memories (depth 2^ADDR_W).
- `DATA_W`, 64, word width.
- `READ_LAT`, 2, cycles from an accepted read request to `readValid`; legal range 1..4.
- `EXPECT_WRITES`, 64, number of result writes that complete a run.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `host_we`  in  1  host write strobe into the ifmap memory.
- `host_addr`  in  ADDR_W  host address, shared by writes to the ifmap memory and reads of the result memory.
- `host_wdata`  in  DATA_W  host write data.
- `host_re`  in  1  host read strobe from the result memory.
- `host_rdata`  out  DATA_W  result-memory read data, registered.
- `start`  in  1  single-cycle run start pulse.
- `DRAMreadEn`  in  1  accelerator read request.
- `DRAMreadAddr`  in  ADDR_W  accelerator read address.
- `DRAMwriteEn`  in  1  accelerator write request.
- `DRAMwriteAddr`  in  ADDR_W  accelerator write address.
- `DRAMwriteData`  in  DATA_W  accelerator write data.
- `ifmap`  out  DATA_W  read response data to the accelerator.
- `readValid`  out  1  `ifmap` carries a response this cycle.
- `busy`  out  1  FSM is in RUN.
- `done`  out  1  FSM is in DONE.
- `wrCount`  out  ADDR_W+1  accepted result writes this run.
- `err`  out  1  sticky protocol-violation flag.

## Operation
- Two arrays of 2^ADDR_W x DATA_W:
  - imem: host-written, accelerator-read.
  - rmem: accelerator-written, host-read.
  - Neither array is reset; contents survive `rst`.
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`.
  - RUN → DONE when `wrCount == EXPECT_WRITES` and the read pipeline is empty.
  - DONE → RUN on `start`. This clears `wrCount` and `err`.
  - `start` while in RUN is ignored.
- IDLE and DONE:
  - `host_we` writes imem.
  - `DRAMreadEn` and `DRAMwriteEn` are ignored and set `err`.
- RUN:
  - `host_we` is ignored and sets `err`.
  - `DRAMreadEn` reads imem[`DRAMreadAddr`] into a READ_LAT-deep valid/data shift pipeline.
  - `DRAMwriteEn` writes rmem[`DRAMwriteAddr`] and increments `wrCount`. Writes to a repeated address still count.
  - A write arriving when `wrCount == EXPECT_WRITES` is dropped and sets `err`.
- `host_re` is honoured in every state: `host_rdata` = rmem[`host_addr`] on the next cycle. If `host_re` is low, `host_rdata` holds.
- Simultaneous `DRAMreadEn` and `DRAMwriteEn` are independent and both are accepted.
- Simultaneous `host_re` with `DRAMwriteEn` to the same address returns the old rmem word (read-before-write).
- When `readValid` is 0, `ifmap` holds the last valid data.

## Timing
- Reset values: state IDLE, pipeline empty, `ifmap` 0, `readValid` 0, `host_rdata` 0, `busy` 0, `done` 0, `wrCount` 0, `err` 0.
- Reset asserted mid-RUN flushes in-flight reads with no response.
- Read request accepted at edge N → `readValid`=1 with the data during cycle N+READ_LAT.
- Back-to-back requests every cycle produce back-to-back responses in order. No stalls and no backpressure.
- The read sees imem contents as of its request edge.
- Write at edge N:
  - rmem is updated at edge N.
  - `wrCount` shows the new value during cycle N+1.
- DONE entry is the edge after both completion conditions hold. `done` and `busy` are registered state decodes.
- `err` sets on the edge after the violation and stays set until reset or a `start` from DONE.

## Test plan
- Reset mid-run:
  - Stimulus: `rst` low while 3 reads are in flight.
  - Required: no `readValid` after release; all outputs at reset values; an imem word preloaded before reset still reads back after a new `start`.
- Preload and streaming reads:
  - Stimulus: preload imem[k]=k*0x0101_0101 for k=0..15; `start`; 16 back-to-back reads of addresses 0..15 with READ_LAT=2.
  - Required: `readValid` high for 16 consecutive cycles beginning 2 cycles after the first request, with `ifmap`=k*0x0101_0101 in order.
- Run completion:
  - Stimulus: EXPECT_WRITES=4; writes to addresses 0,1,1,3 with data A,B,C,D.
  - Required: `wrCount` reaches 4; `done`=1 one cycle later; host reads give rmem[1]=C and rmem[3]=D.
- Protocol violations:
  - Stimulus: read in IDLE; `host_we` in RUN; a 5th write after completion.
  - Required: `err`=1 each time; imem unchanged; no `readValid`; rmem unchanged.
- Restart:
  - Stimulus: `start` in DONE.
  - Required: `wrCount`=0, `err`=0, `busy`=1 on the next cycle; rmem retains prior data.
